// File: rtl/rect_filler.sv
// ============================================================================
// Module   : rect_filler
// Purpose  : Fills an axis-aligned rectangle of a 1024-pixel-wide frame
//            buffer with one colour by pushing 8-pixel DDR2 write bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rect_filler #(
    parameter logic [30:0] FB_BASE = 31'h0010_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    output logic         ready,
    input  logic [23:0]  color,
    input  logic [9:0]   x0,
    input  logic [9:0]   y0,
    input  logic [9:0]   x1,
    input  logic [9:0]   y1,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2
    } state_t;

    state_t         r_state;
    logic [9:0]     r_x0;
    logic [9:0]     r_x1;
    logic [9:0]     r_y1;
    logic [6:0]     r_cx;
    logic [9:0]     r_cy;
    logic [30:0]    r_addr;
    logic [127:0]   r_din;
    logic [15:0]    r_mask;

    logic           w_accept;
    logic           w_degen;
    logic           w_push1;
    logic           w_push2;
    logic           w_row_end;
    logic           w_last;
    logic [6:0]     w_next_cx;
    logic [9:0]     w_next_cy;

    function automatic logic [30:0] f_addr(input logic [6:0] cx, input logic [9:0] cy);
        return FB_BASE + {11'd0, cy, 10'd0} + {21'd0, cx, 3'd0};
    endfunction

    // Pixel p of word 'half' sits at x = {cx, half, p}; bytes outside [lo,hi] are masked.
    function automatic logic [15:0] f_mask(input logic [6:0] cx, input logic half,
                                           input logic [9:0] lo, input logic [9:0] hi);
        logic [15:0] m;
        logic [9:0]  px;
        m = 16'h0000;
        for (int p = 0; p < 4; p++) begin
            px = {cx, half, p[1:0]};
            if ((px < lo) || (px > hi))
                m[4*p +: 4] = 4'hF;
        end
        return m;
    endfunction

    assign w_accept  = valid && (r_state == S_IDLE);
    assign w_degen   = (x0 > x1) || (y0 > y1);
    assign w_push1   = (r_state == S_W1) && !af_full && !wdf_full;
    assign w_push2   = (r_state == S_W2) && !wdf_full;
    // Compare burst indices so x1 = 1023 ends the row without the cursor overflowing.
    assign w_row_end = (r_cx >= r_x1[9:3]);
    assign w_last    = w_row_end && (r_cy >= r_y1);
    assign w_next_cx = w_row_end ? r_x0[9:3] : r_cx + 7'd1;
    assign w_next_cy = w_row_end ? r_cy + 10'd1 : r_cy;

    // Enables are qualified by the live full flags so a push never meets a full FIFO.
    assign ready        = (r_state == S_IDLE);
    assign af_wr_en     = w_push1;
    assign wdf_wr_en    = w_push1 || w_push2;
    assign af_addr_din  = r_addr;
    assign wdf_din      = r_din;
    assign wdf_mask_din = r_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x0    <= 10'd0;
            r_x1    <= 10'd0;
            r_y1    <= 10'd0;
            r_cx    <= 7'd0;
            r_cy    <= 10'd0;
            r_addr  <= 31'd0;
            r_din   <= 128'd0;
            r_mask  <= 16'hFFFF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x0  <= x0;
                        r_x1  <= x1;
                        r_y1  <= y1;
                        r_din <= {4{8'h00, color}};
                        if (!w_degen) begin
                            r_cx    <= x0[9:3];
                            r_cy    <= y0;
                            r_addr  <= f_addr(x0[9:3], y0);
                            r_mask  <= f_mask(x0[9:3], 1'b0, x0, x1);
                            r_state <= S_W1;
                        end
                    end
                end
                S_W1: begin
                    if (w_push1) begin
                        r_mask  <= f_mask(r_cx, 1'b1, r_x0, r_x1);
                        r_state <= S_W2;
                    end
                end
                S_W2: begin
                    if (w_push2) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cx    <= w_next_cx;
                            r_cy    <= w_next_cy;
                            r_addr  <= f_addr(w_next_cx, w_next_cy);
                            r_mask  <= f_mask(w_next_cx, 1'b0, r_x0, r_x1);
                            r_state <= S_W1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rect_filler.sv
// ============================================================================
// Module   : tb_rect_filler
// Purpose  : Directed self-checking bench for rect_filler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rect_filler;

    localparam logic [30:0] FB = 31'h0010_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [23:0]  color;
    logic [9:0]   x0, y0, x1, y1;
    logic         af_full, wdf_full;
    logic [30:0]  af_addr_din;
    logic         af_wr_en;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    logic         wdf_wr_en;

    int n_checks = 0;
    int n_pass   = 0;
    int n_viol   = 0;
    int lat;

    logic [30:0]  q_addr[$];
    logic [127:0] q_data[$];
    logic [15:0]  q_mask[$];

    always #5 clk = ~clk;

    rect_filler #(.FB_BASE(FB)) dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .color(color),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
    );

    // Push monitor, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (!rst) begin
            if (af_wr_en) begin
                q_addr.push_back(af_addr_din);
                if (af_full || !wdf_wr_en) n_viol++;
            end
            if (wdf_wr_en) begin
                q_data.push_back(wdf_din);
                q_mask.push_back(wdf_mask_din);
                if (wdf_full) n_viol++;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_mask.delete();
    endtask

    task automatic request(input logic [9:0] ax0, input logic [9:0] ax1,
                           input logic [9:0] ay0, input logic [9:0] ay1,
                           input logic [23:0] col);
        x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; color = col;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (!ready && n < budget) begin
            tick();
            n++;
        end
        if (!ready) $display("FAIL wait_idle: got timeout expected ready within %0d", budget);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; color = '0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        af_full = 1'b0; wdf_full = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_ready", ready, 1);
        check("rst_af_en", af_wr_en, 0);
        check("rst_wdf_en", wdf_wr_en, 0);
        check("rst_addr", af_addr_din, 0);
        check("rst_din", wdf_din, 0);
        check("rst_mask", wdf_mask_din, 16'hFFFF);
        rst = 1'b0;
        tick();

        // Single aligned burst
        clear_q();
        request(10'd8, 10'd15, 10'd2, 10'd2, 24'h123456);
        check("single_busy", ready, 0);
        wait_idle(50, lat);
        check("single_lat", lat, 2);
        check("single_naf", q_addr.size(), 1);
        check("single_nwd", q_data.size(), 2);
        if (q_addr.size() >= 1) check("single_addr", q_addr[0], FB + 31'd2056);
        if (q_data.size() >= 2) begin
            check("single_d0", q_data[0], {4{32'h0012_3456}});
            check("single_d1", q_data[1], {4{32'h0012_3456}});
            check("single_m0", q_mask[0], 16'h0000);
            check("single_m1", q_mask[1], 16'h0000);
        end

        // Partial burst: pixel 3 in word0, pixels 4 and 5 in word1
        clear_q();
        request(10'd3, 10'd5, 10'd0, 10'd0, 24'h00FF00);
        wait_idle(50, lat);
        check("part_naf", q_addr.size(), 1);
        check("part_nwd", q_data.size(), 2);
        if (q_addr.size() >= 1) check("part_addr", q_addr[0], FB);
        if (q_mask.size() >= 2) begin
            check("part_m0", q_mask[0], 16'h0FFF);
            check("part_m1", q_mask[1], 16'hFF00);
        end

        // Multi-row, with a request issued while busy that must be ignored
        clear_q();
        request(10'd0, 10'd15, 10'd10, 10'd11, 24'hABCDEF);
        x0 = 10'd500; x1 = 10'd600; y0 = 10'd1; y1 = 10'd90; color = 24'h111111;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle(100, lat);
        check("multi_lat", lat, 7);
        check("multi_naf", q_addr.size(), 4);
        check("multi_nwd", q_data.size(), 8);
        if (q_addr.size() >= 4) begin
            check("multi_a0", q_addr[0], FB + 31'd10240);
            check("multi_a1", q_addr[1], FB + 31'd10248);
            check("multi_a2", q_addr[2], FB + 31'd11264);
            check("multi_a3", q_addr[3], FB + 31'd11272);
        end
        for (int i = 0; i < 8 && i < q_data.size(); i++) begin
            check($sformatf("multi_d%0d", i), q_data[i], {4{32'h00AB_CDEF}});
            check($sformatf("multi_m%0d", i), q_mask[i], 16'h0000);
        end

        // Back-pressure: af_full 5 cycles in W1, then wdf_full 3 cycles in W2
        clear_q();
        af_full = 1'b1;
        request(10'd16, 10'd23, 10'd1, 10'd1, 24'h0A0B0C);
        repeat (5) tick();
        check("bp_af_stall", q_data.size() + q_addr.size(), 0);
        af_full = 1'b0;
        tick();
        wdf_full = 1'b1;
        repeat (3) tick();
        check("bp_wd_stall", q_data.size(), 1);
        check("bp_ready_low", ready, 0);
        wdf_full = 1'b0;
        wait_idle(50, lat);
        check("bp_lat", lat, 1);
        check("bp_naf", q_addr.size(), 1);
        check("bp_nwd", q_data.size(), 2);
        if (q_addr.size() >= 1) check("bp_addr", q_addr[0], FB + 31'd1040);
        check("bp_viol", n_viol, 0);

        // Reset in W2 of a 20-burst fill
        clear_q();
        request(10'd0, 10'd159, 10'd0, 10'd0, 24'h555555);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rmid_ready", ready, 1);
        check("rmid_af_en", af_wr_en, 0);
        check("rmid_wdf_en", wdf_wr_en, 0);
        clear_q();
        request(10'd0, 10'd0, 10'd0, 10'd0, 24'h777777);
        wait_idle(50, lat);
        repeat (3) tick();
        check("rmid_naf", q_addr.size(), 1);
        check("rmid_nwd", q_data.size(), 2);
        if (q_addr.size() >= 1) check("rmid_addr", q_addr[0], FB);
        if (q_mask.size() >= 2) begin
            check("rmid_m0", q_mask[0], 16'hFFF0);
            check("rmid_m1", q_mask[1], 16'hFFFF);
        end

        // Degenerate rectangle
        clear_q();
        request(10'd9, 10'd4, 10'd0, 10'd0, 24'h999999);
        check("degen_ready", ready, 1);
        repeat (4) tick();
        check("degen_push", q_addr.size() + q_data.size(), 0);

        // Right edge of the frame
        clear_q();
        request(10'd1016, 10'd1023, 10'd599, 10'd599, 24'hFEDCBA);
        wait_idle(50, lat);
        check("edge_lat", lat, 2);
        repeat (3) tick();
        check("edge_idle", ready, 1);
        check("edge_naf", q_addr.size(), 1);
        check("edge_nwd", q_data.size(), 2);
        if (q_addr.size() >= 1) check("edge_addr", q_addr[0], FB + 31'd614392);
        if (q_mask.size() >= 2) begin
            check("edge_m0", q_mask[0], 16'h0000);
            check("edge_m1", q_mask[1], 16'h0000);
        end
        check("final_viol", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
